// File: rtl/lm32_dtlb_assoc.sv
// lm32_dtlb_assoc: N-way set-associative data TLB.
// Indexes with the X-stage address, compares tags in M, translates the M-stage address.
// Per-entry write protection and the fault_int port are built only when
// CFG_DTLB_WRITE_PROTECT_EN is defined.
module lm32_dtlb_assoc #(
    parameter int         sets             = 256,
    parameter int         ways             = 2,
    parameter int         page_size        = 4096,
    parameter logic [4:0] CSR_TLB_PADDRESS = 5'h11,
    parameter logic [4:0] CSR_TLB_VADDRESS = 5'h12
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        enable,
    input  logic        stall_x,
    input  logic        stall_m,
    input  logic [31:0] address_x,
    input  logic [31:0] address_m,
    input  logic        load_q_m,
    input  logic        store_q_m,
    input  logic [4:0]  csr,
    input  logic [31:0] csr_write_data,
    input  logic        csr_write_enable,
    input  logic        exception_m,
    output logic [31:0] physical_load_store_address_m,
    output logic        stall_request,
    output logic        miss_int,
`ifdef CFG_DTLB_WRITE_PROTECT_EN
    output logic        fault_int,
`endif
    output logic [31:0] csr_read_data
);
    localparam int OFFSET_W = $clog2(page_size);
    localparam int INDEX_W  = $clog2(sets);
    localparam int PFN_W    = 32 - OFFSET_W;
    localparam int TAG_W    = PFN_W - INDEX_W;
    localparam int VICTIM_W = (ways > 1) ? $clog2(ways) : 1;
`ifdef CFG_DTLB_WRITE_PROTECT_EN
    localparam int ENTRY_W  = 2 + TAG_W + PFN_W;   // {valid, ro, tag, pfn}
`else
    localparam int ENTRY_W  = 1 + TAG_W + PFN_W;   // {valid, tag, pfn}
`endif
    localparam logic [4:0] CMD_FLUSH = 5'h01;
    localparam logic [4:0] CMD_INVAL = 5'h10;

    typedef enum logic {S_CHECK, S_FLUSH} state_t;

    state_t               state_q, state_d;
    logic [INDEX_W-1:0]   flush_set_q, flush_set_d;
    logic [31:0]          vaddr_q, vaddr_d;
    logic                 upd_q, upd_d;
    logic [PFN_W-1:0]     upd_pfn_q, upd_pfn_d;
    logic                 inv_q, inv_d;
    logic [VICTIM_W-1:0]  victim_q, victim_d;
    logic                 miss_q, miss_d;
    logic [31:0]          csr_rd_q, csr_rd_d;
`ifdef CFG_DTLB_WRITE_PROTECT_EN
    logic                 upd_ro_q, upd_ro_d;
    logic                 fault_q, fault_d;
`endif

    logic                 csr_vaddr_wr, csr_paddr_wr, rd_en_x;
    logic [INDEX_W-1:0]   idx_x, idx_v, maint_idx, wr_idx;
    logic [TAG_W-1:0]     tag_m, tag_v;
    logic [ENTRY_W-1:0]   wr_data;
    logic [ways-1:0]      we_vec, hit_vec, same_vec, ro_vec;
    logic [ways-1:0][PFN_W-1:0] way_pfn;
    logic                 hit, hit_ro, same_any, miss, fault;
    logic [PFN_W-1:0]     hit_pfn;
    logic [VICTIM_W-1:0]  same_sel, target;
    logic                 unused_ok;

    assign csr_vaddr_wr = csr_write_enable && csr_write_data[0] && (csr == CSR_TLB_VADDRESS);
    assign csr_paddr_wr = csr_write_enable && csr_write_data[0] && (csr == CSR_TLB_PADDRESS);
    assign rd_en_x      = !stall_x || !stall_m;
    assign idx_x        = address_x[OFFSET_W +: INDEX_W];
    assign idx_v        = vaddr_q[OFFSET_W +: INDEX_W];
    assign tag_m        = address_m[31 -: TAG_W];
    assign tag_v        = vaddr_q[31 -: TAG_W];
    // An invalidate looks up the index being written this cycle; an update uses the latched vaddr.
    assign maint_idx    = csr_vaddr_wr ? csr_write_data[OFFSET_W +: INDEX_W] : idx_v;
    assign unused_ok    = &{1'b0, address_x, vaddr_q};

    for (genvar gi = 0; gi < ways; gi++) begin : g_way
        logic [ENTRY_W-1:0] mem [sets];
        logic [ENTRY_W-1:0] look_q;
        logic [ENTRY_W-1:0] maint_q;
        logic               unused_maint;
        // One shared write port; registered lookup port (X index) and maintenance port.
        always_ff @(posedge clk_i) begin
            if (we_vec[gi])
                mem[wr_idx] <= wr_data;
            if (rd_en_x)
                look_q <= mem[idx_x];
            maint_q <= mem[maint_idx];
        end
        assign hit_vec[gi]  = look_q[ENTRY_W-1] && (look_q[PFN_W +: TAG_W] == tag_m);
        assign same_vec[gi] = maint_q[ENTRY_W-1] && (maint_q[PFN_W +: TAG_W] == tag_v);
        assign way_pfn[gi]  = look_q[PFN_W-1:0];
`ifdef CFG_DTLB_WRITE_PROTECT_EN
        assign ro_vec[gi]   = look_q[ENTRY_W-2];
`else
        assign ro_vec[gi]   = 1'b0;
`endif
        assign unused_maint = &{1'b0, maint_q};
    end

    // Priority select: lowest-numbered hitting way and lowest same-tag way win.
    always_comb begin
        hit      = 1'b0;
        hit_pfn  = '0;
        hit_ro   = 1'b0;
        same_any = 1'b0;
        same_sel = '0;
        for (int w = ways - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit     = 1'b1;
                hit_pfn = way_pfn[w];
                hit_ro  = ro_vec[w];
            end
            if (same_vec[w]) begin
                same_any = 1'b1;
                same_sel = VICTIM_W'(w);
            end
        end
        target = same_any ? same_sel : victim_q;
    end

    assign miss = enable && (load_q_m || store_q_m) && !hit;
`ifdef CFG_DTLB_WRITE_PROTECT_EN
    assign fault     = enable && store_q_m && hit && hit_ro;
    assign fault_int = fault || fault_q;
`else
    assign fault     = 1'b0;
`endif
    assign physical_load_store_address_m = enable ? {hit_pfn, address_m[OFFSET_W-1:0]} : address_m;
    assign miss_int      = miss || miss_q;
    assign stall_request = (state_q == S_FLUSH);
    assign csr_read_data = csr_rd_q;

    // RAM write source: flush sweep, pending update, or pending invalidate.
    always_comb begin
        we_vec  = '0;
        wr_idx  = idx_v;
        wr_data = '0;
        if (state_q == S_FLUSH) begin
            we_vec = '1;
            wr_idx = flush_set_q;
        end else if (upd_q) begin
            for (int w = 0; w < ways; w++)
                we_vec[w] = (target == VICTIM_W'(w));
`ifdef CFG_DTLB_WRITE_PROTECT_EN
            wr_data = {1'b1, upd_ro_q, tag_v, upd_pfn_q};
`else
            wr_data = {1'b1, tag_v, upd_pfn_q};
`endif
        end else if (inv_q) begin
            we_vec = same_vec;
        end
    end

    // Next-state logic: FSM, CSR latches, sticky miss/fault, replacement pointer.
    always_comb begin
        state_d     = state_q;
        flush_set_d = flush_set_q;
        vaddr_d     = vaddr_q;
        upd_d       = 1'b0;
        upd_pfn_d   = upd_pfn_q;
        inv_d       = 1'b0;
        victim_d    = victim_q;
        miss_d      = miss_q;
        csr_rd_d    = csr_rd_q;
`ifdef CFG_DTLB_WRITE_PROTECT_EN
        upd_ro_d    = upd_ro_q;
        fault_d     = exception_m ? 1'b0 : (fault ? 1'b1 : fault_q);
`endif
        case (state_q)
            S_CHECK: begin
                if (csr_vaddr_wr && csr_write_data[5:1] == CMD_FLUSH) begin
                    state_d     = S_FLUSH;
                    flush_set_d = INDEX_W'(sets - 1);
                end
                inv_d = csr_vaddr_wr && (csr_write_data[5:1] == CMD_INVAL);
                upd_d = csr_paddr_wr;
                if (miss || fault)
                    csr_rd_d = address_m;
            end
            default: begin
                flush_set_d = flush_set_q - INDEX_W'(1);
                if (flush_set_q == '0)
                    state_d = S_CHECK;
            end
        endcase
        if (csr_vaddr_wr)
            vaddr_d = {csr_write_data[31:1], 1'b0};
        if (csr_paddr_wr) begin
            upd_pfn_d = csr_write_data[31:OFFSET_W];
`ifdef CFG_DTLB_WRITE_PROTECT_EN
            upd_ro_d  = csr_write_data[1];
`endif
        end
        if (upd_q && !same_any)
            victim_d = (victim_q == VICTIM_W'(ways - 1)) ? '0 : victim_q + VICTIM_W'(1);
        miss_d = exception_m ? 1'b0 : (miss ? 1'b1 : miss_q);
    end

    // State registers; reset restarts a full flush.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_FLUSH;
            flush_set_q <= INDEX_W'(sets - 1);
            vaddr_q     <= '0;
            upd_q       <= 1'b0;
            upd_pfn_q   <= '0;
            inv_q       <= 1'b0;
            victim_q    <= '0;
            miss_q      <= 1'b0;
            csr_rd_q    <= '0;
`ifdef CFG_DTLB_WRITE_PROTECT_EN
            upd_ro_q    <= 1'b0;
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            flush_set_q <= flush_set_d;
            vaddr_q     <= vaddr_d;
            upd_q       <= upd_d;
            upd_pfn_q   <= upd_pfn_d;
            inv_q       <= inv_d;
            victim_q    <= victim_d;
            miss_q      <= miss_d;
            csr_rd_q    <= csr_rd_d;
`ifdef CFG_DTLB_WRITE_PROTECT_EN
            upd_ro_q    <= upd_ro_d;
            fault_q     <= fault_d;
`endif
        end
    end
endmodule
